// File: rtl/control_pipe.sv
// ID/EX control stage of the pipelined RV32I core: decodes the ID instruction, registers the
// control word into EX, and sequences load-use bubbles, multi-cycle M-extension ops, flush and stall.
module control_pipe #(
    parameter int MULDIV_EN = 1,
    parameter int MUL_LAT   = 3,
    parameter int DIV_LAT   = 33,
    parameter int CNT_W     = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    output logic        id_ready,
    input  logic        mem_stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [27:0] ex_ctrl,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic        ex_muldiv,
    output logic        ex_busy,
    output logic        ex_illegal
);
    // Field order is the bit layout the execute datapath slices ex_ctrl by.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] aluop;
        logic [2:0] cmpop;
        logic       alumux1_sel;
        logic [2:0] alumux2_sel;
        logic       cmpmux_sel;
        logic [3:0] regfilemux_sel;
        logic       load_regfile;
        logic       dmem_read;
        logic       dmem_write;
        logic [2:0] funct3;
    } ctrl_t;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SRA  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] CMP_BLT  = 3'b100;
    localparam logic [2:0] CMP_BLTU = 3'b110;
    localparam logic       MUX1_PC  = 1'b1;
    localparam logic [2:0] MUX2_I   = 3'd0;
    localparam logic [2:0] MUX2_U   = 3'd1;
    localparam logic [2:0] MUX2_B   = 3'd2;
    localparam logic [2:0] MUX2_S   = 3'd3;
    localparam logic [2:0] MUX2_J   = 3'd4;
    localparam logic [2:0] MUX2_RS2 = 3'd5;
    localparam logic       CMP_IMM  = 1'b1;
    localparam logic [3:0] RF_ALU   = 4'd0;
    localparam logic [3:0] RF_BR    = 4'd1;
    localparam logic [3:0] RF_U     = 4'd2;
    localparam logic [3:0] RF_LW    = 4'd3;
    localparam logic [3:0] RF_PC4   = 4'd4;
    localparam logic [3:0] RF_LB    = 4'd5;
    localparam logic [3:0] RF_LBU   = 4'd6;
    localparam logic [3:0] RF_LH    = 4'd7;
    localparam logic [3:0] RF_LHU   = 4'd8;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = id_instr[6:0];
    assign rd     = id_instr[11:7];
    assign funct3 = id_instr[14:12];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];
    assign funct7 = id_instr[31:25];

    ctrl_t            dec;
    ctrl_t            ex_word;
    logic             dec_muldiv;
    logic             dec_illegal;
    logic             use_rs1;
    logic             use_rs2;
    logic [CNT_W-1:0] count;
    logic             stall_lu;
    logic             stall;

    always_comb begin
        dec         = '0;
        dec_muldiv  = 1'b0;
        dec_illegal = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        dec.opcode  = opcode;
        dec.funct3  = funct3;
        case (opcode)
            OP_LUI: begin
                dec.load_regfile   = 1'b1;
                dec.regfilemux_sel = RF_U;
            end
            OP_AUIPC: begin
                dec.load_regfile = 1'b1;
                dec.alumux1_sel  = MUX1_PC;
                dec.alumux2_sel  = MUX2_U;
            end
            OP_JAL: begin
                dec.load_regfile   = 1'b1;
                dec.alumux1_sel    = MUX1_PC;
                dec.alumux2_sel    = MUX2_J;
                dec.regfilemux_sel = RF_PC4;
            end
            OP_JALR: begin
                dec.load_regfile   = 1'b1;
                dec.alumux2_sel    = MUX2_I;
                dec.regfilemux_sel = RF_PC4;
                use_rs1            = 1'b1;
            end
            OP_BR: begin
                dec.alumux1_sel = MUX1_PC;
                dec.alumux2_sel = MUX2_B;
                dec.cmpop       = funct3;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
            end
            OP_LOAD: begin
                dec.load_regfile = 1'b1;
                dec.dmem_read    = 1'b1;
                dec.alumux2_sel  = MUX2_I;
                use_rs1          = 1'b1;
                case (funct3)
                    3'b000:  dec.regfilemux_sel = RF_LB;
                    3'b001:  dec.regfilemux_sel = RF_LH;
                    3'b100:  dec.regfilemux_sel = RF_LBU;
                    3'b101:  dec.regfilemux_sel = RF_LHU;
                    default: dec.regfilemux_sel = RF_LW;
                endcase
            end
            OP_STORE: begin
                dec.dmem_write  = 1'b1;
                dec.alumux2_sel = MUX2_S;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
            end
            OP_IMM: begin
                dec.load_regfile = 1'b1;
                dec.alumux2_sel  = MUX2_I;
                use_rs1          = 1'b1;
                case (funct3)
                    3'b010: begin
                        dec.cmpop          = CMP_BLT;
                        dec.cmpmux_sel     = CMP_IMM;
                        dec.regfilemux_sel = RF_BR;
                    end
                    3'b011: begin
                        dec.cmpop          = CMP_BLTU;
                        dec.cmpmux_sel     = CMP_IMM;
                        dec.regfilemux_sel = RF_BR;
                    end
                    3'b101:  dec.aluop = funct7[5] ? ALU_SRA : ALU_SRL;
                    default: dec.aluop = funct3;
                endcase
            end
            OP_REG: begin
                dec.load_regfile = 1'b1;
                dec.alumux2_sel  = MUX2_RS2;
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
                if (funct7 == 7'b0000001) begin
                    if (MULDIV_EN != 0) begin
                        dec_muldiv         = 1'b1;
                        dec.aluop          = funct3;
                        dec.regfilemux_sel = RF_ALU;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end else begin
                    case (funct3)
                        3'b000:  dec.aluop = funct7[5] ? ALU_SUB : ALU_ADD;
                        3'b010: begin
                            dec.cmpop          = CMP_BLT;
                            dec.regfilemux_sel = RF_BR;
                        end
                        3'b011: begin
                            dec.cmpop          = CMP_BLTU;
                            dec.regfilemux_sel = RF_BR;
                        end
                        3'b101:  dec.aluop = funct7[5] ? ALU_SRA : ALU_SRL;
                        default: dec.aluop = funct3;
                    endcase
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        // An illegal instruction must never write architectural state.
        if (dec_illegal) begin
            dec.load_regfile = 1'b0;
            dec.dmem_read    = 1'b0;
            dec.dmem_write   = 1'b0;
        end
    end

    assign stall_lu = ex_valid && ex_word.dmem_read && (ex_rd != 5'd0) &&
                      ((use_rs1 && (ex_rd == rs1)) || (use_rs2 && (ex_rd == rs2)));
    assign ex_busy  = (count != '0) && ex_valid && ex_muldiv;
    assign stall    = stall_lu || ex_busy || mem_stall;
    assign id_ready = !stall || flush;
    assign ex_ctrl  = ex_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_word    <= '0;
            ex_rd      <= 5'd0;
            ex_rs1     <= 5'd0;
            ex_rs2     <= 5'd0;
            ex_muldiv  <= 1'b0;
            ex_illegal <= 1'b0;
            count      <= '0;
        end else if (mem_stall) begin
            // Downstream back-pressure freezes EX state and the counter.
        end else if (ex_busy) begin
            count <= count - CNT_W'(1);
        end else if (flush || stall_lu || !id_valid) begin
            ex_valid   <= 1'b0;
            ex_word    <= '0;
            ex_rd      <= 5'd0;
            ex_rs1     <= 5'd0;
            ex_rs2     <= 5'd0;
            ex_muldiv  <= 1'b0;
            ex_illegal <= 1'b0;
            count      <= '0;
        end else begin
            ex_valid   <= 1'b1;
            ex_word    <= dec;
            ex_rd      <= rd;
            ex_rs1     <= rs1;
            ex_rs2     <= rs2;
            ex_muldiv  <= dec_muldiv;
            ex_illegal <= dec_illegal;
            count      <= dec_muldiv ? (funct3[2] ? DIV_CNT : MUL_CNT) : '0;
        end
    end
endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench for control_pipe: directed instruction stream, expected EX contents queued at
// issue and checked by a monitor when each instruction leaves EX.
module tb_control_pipe;
    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        mem_stall;
    logic        flush;

    logic        id_ready, ex_valid, ex_muldiv, ex_busy, ex_illegal;
    logic [27:0] ex_ctrl;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;

    logic        n_id_ready, n_ex_valid, n_ex_muldiv, n_ex_busy, n_ex_illegal;
    logic [27:0] n_ex_ctrl;
    logic [4:0]  n_ex_rd, n_ex_rs1, n_ex_rs2;

    control_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_ready(id_ready), .mem_stall(mem_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_muldiv(ex_muldiv), .ex_busy(ex_busy), .ex_illegal(ex_illegal)
    );

    control_pipe #(.MULDIV_EN(0)) u_nomd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_ready(n_id_ready), .mem_stall(mem_stall), .flush(flush),
        .ex_valid(n_ex_valid), .ex_ctrl(n_ex_ctrl), .ex_rd(n_ex_rd), .ex_rs1(n_ex_rs1),
        .ex_rs2(n_ex_rs2), .ex_muldiv(n_ex_muldiv), .ex_busy(n_ex_busy),
        .ex_illegal(n_ex_illegal)
    );

    localparam logic [31:0] I_LUI   = 32'h12345537; // lui   x10,0x12345
    localparam logic [31:0] I_AUIPC = 32'h00001597; // auipc x11,1
    localparam logic [31:0] I_JAL   = 32'h010000EF; // jal   x1,16
    localparam logic [31:0] I_BEQ   = 32'h00208463; // beq   x1,x2,8
    localparam logic [31:0] I_SLTI  = 32'h0030A613; // slti  x12,x1,3
    localparam logic [31:0] I_SRAI  = 32'h4020D693; // srai  x13,x1,2
    localparam logic [31:0] I_SUB   = 32'h404184B3; // sub   x9,x3,x4
    localparam logic [31:0] I_BAD   = 32'h0000007F; // unknown opcode
    localparam logic [31:0] I_LW5   = 32'h0000A283; // lw    x5,0(x1)
    localparam logic [31:0] I_LW0   = 32'h0000A003; // lw    x0,0(x1)
    localparam logic [31:0] I_ADD   = 32'h00228333; // add   x6,x5,x2
    localparam logic [31:0] I_ADD0  = 32'h00200333; // add   x6,x0,x2
    localparam logic [31:0] I_SW    = 32'h0050A423; // sw    x5,8(x1)
    localparam logic [31:0] I_JALR  = 32'h000280E7; // jalr  x1,0(x5)
    localparam logic [31:0] I_ADDI4 = 32'h00508213; // addi  x4,x1,5
    localparam logic [31:0] I_ADDI8 = 32'hFFF10413; // addi  x8,x2,-1
    localparam logic [31:0] I_MUL   = 32'h022081B3; // mul   x3,x1,x2
    localparam logic [31:0] I_DIV   = 32'h0220C3B3; // div   x7,x1,x2

    typedef struct {
        logic [27:0] ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        md;
        logic        il;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   busy_cycles = 0;

    // Fields: opcode, aluop, cmpop, alumux1, alumux2, cmpmux, regfilemux, load_regfile, dmem_read, dmem_write, funct3
    function automatic logic [27:0] cw(input logic [31:0] ins, input int alu, input int cmp,
                                       input int m1, input int m2, input int cm, input int rm,
                                       input int ld, input int rdm, input int wr);
        return {ins[6:0], 3'(alu), 3'(cmp), 1'(m1), 3'(m2), 1'(cm), 4'(rm),
                1'(ld), 1'(rdm), 1'(wr), ins[14:12]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Monitor: an instruction leaves EX on the cycle it is valid and neither busy nor frozen.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ex_busy) busy_cycles++;
            if (rst_n && ex_valid && !ex_busy && !mem_stall) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ex: got instr rd=%0d ctrl=0x%0h, expected none",
                             ex_rd, ex_ctrl);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ex_ctrl", 32'(ex_ctrl), 32'(mon_e.ctrl));
                    check("ex_rd", 32'(ex_rd), 32'(mon_e.rd));
                    check("ex_rs1", 32'(ex_rs1), 32'(mon_e.rs1));
                    check("ex_rs2", 32'(ex_rs2), 32'(mon_e.rs2));
                    check("ex_muldiv", 32'(ex_muldiv), 32'(mon_e.md));
                    check("ex_illegal", 32'(ex_illegal), 32'(mon_e.il));
                    $display("[TB] retired rd=%0d ctrl=0x%0h", ex_rd, ex_ctrl);
                end
            end
        end
    end

    // Presents one instruction at ID until accepted; returns the number of id_ready=0 cycles.
    task automatic issue(input logic [31:0] ins, input logic [27:0] c, input logic md,
                         input logic il, output int stalls);
        exp_t e;
        bit   ok;
        id_valid = 1'b1;
        id_instr = ins;
        stalls   = 0;
        ok       = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (id_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        e.ctrl = c;
        e.rd   = ins[11:7];
        e.rs1  = ins[19:15];
        e.rs2  = ins[24:20];
        e.md   = md;
        e.il   = il;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        id_instr = 32'd0;
        $display("[TB] issued 0x%08h after %0d stall cycles", ins, stalls);
    endtask

    task automatic run(input string name, input logic [31:0] ins, input logic [27:0] c,
                       input logic md, input logic il, input int exp_stalls);
        int s;
        issue(ins, c, md, il, s);
        check(name, 32'(s), 32'(exp_stalls));
    endtask

    logic [27:0] c_mul, c_div, c_addi4, c_addi8, c_sub;
    int s, b0;

    initial begin
        c_mul   = cw(I_MUL, 3'b000, 0, 0, 5, 0, 0, 1, 0, 0);
        c_div   = cw(I_DIV, 3'b100, 0, 0, 5, 0, 0, 1, 0, 0);
        c_addi4 = cw(I_ADDI4, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        c_addi8 = cw(I_ADDI8, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        c_sub   = cw(I_SUB, 3'b011, 0, 0, 5, 0, 0, 1, 0, 0);
        rst_n = 1'b0; id_valid = 1'b0; id_instr = 32'd0; mem_stall = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_ex_busy", 32'(ex_busy), 32'd0);
        check("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
        check("rst_ex_rd", 32'(ex_rd), 32'd0);
        check("rst_ex_muldiv", 32'(ex_muldiv), 32'd0);
        check("rst_ex_illegal", 32'(ex_illegal), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Decode sweep and load-use hazards, issued back to back.
        run("lui_stalls",   I_LUI,   cw(I_LUI, 0, 0, 0, 0, 0, 2, 1, 0, 0), 0, 0, 0);
        run("auipc_stalls", I_AUIPC, cw(I_AUIPC, 0, 0, 1, 1, 0, 0, 1, 0, 0), 0, 0, 0);
        run("jal_stalls",   I_JAL,   cw(I_JAL, 0, 0, 1, 4, 0, 4, 1, 0, 0), 0, 0, 0);
        run("beq_stalls",   I_BEQ,   cw(I_BEQ, 0, 0, 1, 2, 0, 0, 0, 0, 0), 0, 0, 0);
        run("slti_stalls",  I_SLTI,  cw(I_SLTI, 0, 4, 0, 0, 1, 1, 1, 0, 0), 0, 0, 0);
        run("srai_stalls",  I_SRAI,  cw(I_SRAI, 2, 0, 0, 0, 0, 0, 1, 0, 0), 0, 0, 0);
        run("sub_stalls",   I_SUB,   c_sub, 0, 0, 0);
        run("bad_stalls",   I_BAD,   cw(I_BAD, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0);
        run("lw5_stalls",   I_LW5,   cw(I_LW5, 0, 0, 0, 0, 0, 3, 1, 1, 0), 0, 0, 0);
        run("lu_add_rs1",   I_ADD,   cw(I_ADD, 0, 0, 0, 5, 0, 0, 1, 0, 0), 0, 0, 1);
        run("lw5b_stalls",  I_LW5,   cw(I_LW5, 0, 0, 0, 0, 0, 3, 1, 1, 0), 0, 0, 0);
        run("lu_sw_rs2",    I_SW,    cw(I_SW, 0, 0, 0, 3, 0, 0, 0, 0, 1), 0, 0, 1);
        run("lw0_stalls",   I_LW0,   cw(I_LW0, 0, 0, 0, 0, 0, 3, 1, 1, 0), 0, 0, 0);
        run("lu_x0_none",   I_ADD0,  cw(I_ADD0, 0, 0, 0, 5, 0, 0, 1, 0, 0), 0, 0, 0);
        run("lw5c_stalls",  I_LW5,   cw(I_LW5, 0, 0, 0, 0, 0, 3, 1, 1, 0), 0, 0, 0);
        run("lu_jalr_rs1",  I_JALR,  cw(I_JALR, 0, 0, 0, 0, 0, 4, 1, 0, 0), 0, 0, 1);
        run("lw5d_stalls",  I_LW5,   cw(I_LW5, 0, 0, 0, 0, 0, 3, 1, 1, 0), 0, 0, 0);
        run("lu_imm_nors2", I_ADDI4, c_addi4, 0, 0, 0);

        // Multiply: two busy cycles, then addi enters EX.
        b0 = busy_cycles;
        run("mul_stalls", I_MUL, c_mul, 1, 0, 0);
        run("mul_next_stalls", I_ADDI4, c_addi4, 0, 0, 2);
        check("mul_busy_cycles", 32'(busy_cycles - b0), 32'd2);

        // Divide: 32 busy cycles; the M-disabled instance flags the same word illegal.
        b0 = busy_cycles;
        run("div_stalls", I_DIV, c_div, 1, 0, 0);
        check("nomd_valid", 32'(n_ex_valid), 32'd1);
        check("nomd_illegal", 32'(n_ex_illegal), 32'd1);
        check("nomd_load_regfile", 32'(n_ex_ctrl[5]), 32'd0);
        check("nomd_muldiv", 32'(n_ex_muldiv), 32'd0);
        check("nomd_busy", 32'(n_ex_busy), 32'd0);
        run("div_next_stalls", I_ADDI8, c_addi8, 0, 0, 32);
        check("div_busy_cycles", 32'(busy_cycles - b0), 32'd32);

        // Flush with addi at ID: next EX is a bubble.
        run("pre_flush_stalls", I_ADDI4, c_addi4, 0, 0, 0);
        id_valid = 1'b1; id_instr = I_ADDI8; flush = 1'b1;
        @(negedge clk);
        check("flush_id_ready", 32'(id_ready), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0; id_valid = 1'b0; id_instr = 32'd0;
        @(negedge clk);
        check("flush_bubble_valid", 32'(ex_valid), 32'd0);
        check("flush_bubble_ctrl", 32'(ex_ctrl), 32'd0);

        // Flush during a div busy cycle: sub is killed, div completes its full latency.
        b0 = busy_cycles;
        @(posedge clk);
        #1;
        run("div2_stalls", I_DIV, c_div, 1, 0, 0);
        id_valid = 1'b1; id_instr = I_SUB; flush = 1'b1;
        @(negedge clk);
        check("flush_busy_id_ready", 32'(id_ready), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        run("flush_busy_next_stalls", I_ADDI4, c_addi4, 0, 0, 31);
        check("flush_busy_cycles", 32'(busy_cycles - b0), 32'd32);

        // mem_stall for 4 cycles during a mul: counter and EX frozen.
        b0 = busy_cycles;
        run("mul2_stalls", I_MUL, c_mul, 1, 0, 0);
        fork
            begin
                mem_stall = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    check("mstall_ctrl", 32'(ex_ctrl), 32'(c_mul));
                    check("mstall_busy", 32'(ex_busy), 32'd1);
                end
                @(posedge clk);
                #1;
                mem_stall = 1'b0;
            end
            begin
                issue(I_ADDI8, c_addi8, 1'b0, 1'b0, s);
                check("mstall_next_stalls", 32'(s), 32'd6);
            end
        join
        check("mstall_busy_cycles", 32'(busy_cycles - b0), 32'd6);

        // Reset in the middle of a divide.
        run("div3_stalls", I_DIV, c_div, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ex_valid", 32'(ex_valid), 32'd0);
        check("midrst_ex_busy", 32'(ex_busy), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run("postrst_stalls", I_ADDI4, c_addi4, 0, 0, 0);
        check("postrst_ex_valid", 32'(ex_valid), 32'd1);
        check("postrst_ex_rd", 32'(ex_rd), 32'd4);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
